// File: rtl/core_wb_rob_if.sv
// Signal bundle between decode/late-result units and the in-order completion buffer.
// The master side is the issuing pipeline; the slave side is core_wb_rob.
interface core_wb_rob_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 4
);
   localparam int TAG_W = $clog2(DEPTH);

   logic              ex_halt;
   logic              ex_flush;
   logic              id_valid;
   logic              id_ready;
   logic              id_wb;
   logic [REG_AW-1:0] id_regd;
   logic [ADDR_W-1:0] id_pc;
   logic              id_done;
   logic [DATA_W-1:0] id_data;
   logic [TAG_W-1:0]  id_tag;
   logic              cpl_valid;
   logic [TAG_W-1:0]  cpl_tag;
   logic [DATA_W-1:0] cpl_data;
   logic              wb;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] ex_pc;
   logic [REG_AW-1:0] rd_a_addr;
   logic [REG_AW-1:0] rd_b_addr;
   logic              fwd_a_hit;
   logic              fwd_b_hit;
   logic [DATA_W-1:0] fwd_a_data;
   logic [DATA_W-1:0] fwd_b_data;
   logic              stall_a;
   logic              stall_b;

   modport master (
      output ex_halt, ex_flush,
      output id_valid, id_wb, id_regd, id_pc, id_done, id_data,
      input  id_ready, id_tag,
      output cpl_valid, cpl_tag, cpl_data,
      input  wb, wb_addr, wb_data, ex_pc,
      output rd_a_addr, rd_b_addr,
      input  fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, stall_a, stall_b
   );

   modport slave (
      input  ex_halt, ex_flush,
      input  id_valid, id_wb, id_regd, id_pc, id_done, id_data,
      output id_ready, id_tag,
      input  cpl_valid, cpl_tag, cpl_data,
      output wb, wb_addr, wb_data, ex_pc,
      input  rd_a_addr, rd_b_addr,
      output fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data, stall_a, stall_b
   );
endinterface

// File: rtl/core_wb_rob.sv
// Execute/writeback stage: DEPTH-entry circular completion buffer that retires
// results to the register file in program order and forwards to decode.
module core_wb_rob #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rst,
   core_wb_rob_if.slave bus
);
   localparam int TAG_W = $clog2(DEPTH);
   localparam int CNT_W = TAG_W + 1;

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [DEPTH-1:0]  done_q, done_d;
   logic [DEPTH-1:0]  wb_q;
   logic [REG_AW-1:0] regd_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              head_vld;
   logic              issue;
   logic              retire;
   logic              cpl_fire;
   logic [TAG_W-1:0]  age_idx [DEPTH];

   logic              a_found, a_done, b_found, b_done;
   logic [DATA_W-1:0] a_data, b_data;

   assign head_vld     = valid_q[head_q];
   assign bus.id_ready = (count_q < CNT_W'(DEPTH)) && !bus.ex_halt;
   assign issue        = bus.id_valid && bus.id_ready && !bus.ex_flush;
   assign retire       = head_vld && done_q[head_q] && !bus.ex_halt;
   assign cpl_fire     = bus.cpl_valid && valid_q[bus.cpl_tag] &&
                         !done_q[bus.cpl_tag] && !bus.ex_flush;

   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.ex_flush) begin
         valid_d = '0;
         done_d  = '0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_W'(1);
         end
         if (issue) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = bus.id_done;
            tail_d          = tail_q + TAG_W'(1);
         end
         if (cpl_fire) begin
            done_d[bus.cpl_tag] = 1'b1;
         end
         if (issue && !retire) begin
            count_d = count_q + CNT_W'(1);
         end else if (retire && !issue) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset: every read is qualified by valid_q.
   always_ff @(posedge clk) begin
      if (issue) begin
         wb_q[tail_q]   <= bus.id_wb;
         regd_q[tail_q] <= bus.id_regd;
         pc_q[tail_q]   <= bus.id_pc;
         data_q[tail_q] <= bus.id_done ? bus.id_data : '0;
      end
      if (cpl_fire) begin
         data_q[bus.cpl_tag] <= bus.cpl_data;
      end
   end

   assign bus.wb      = retire && wb_q[head_q];
   assign bus.wb_addr = head_vld ? regd_q[head_q] : '0;
   assign bus.wb_data = head_vld ? data_q[head_q] : '0;
   assign bus.ex_pc   = head_vld ? pc_q[head_q]   : '0;
   assign bus.id_tag  = tail_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         age_idx[i] = head_q + TAG_W'(i);
      end
   end

   // Walk oldest to youngest so the last match left standing is the youngest producer.
   always_comb begin
      a_found = 1'b0;
      a_done  = 1'b0;
      a_data  = '0;
      b_found = 1'b0;
      b_done  = 1'b0;
      b_data  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[age_idx[i]] && wb_q[age_idx[i]] &&
             (regd_q[age_idx[i]] == bus.rd_a_addr)) begin
            a_found = 1'b1;
            a_done  = done_q[age_idx[i]];
            a_data  = data_q[age_idx[i]];
         end
         if (valid_q[age_idx[i]] && wb_q[age_idx[i]] &&
             (regd_q[age_idx[i]] == bus.rd_b_addr)) begin
            b_found = 1'b1;
            b_done  = done_q[age_idx[i]];
            b_data  = data_q[age_idx[i]];
         end
      end
   end

   assign bus.fwd_a_hit  = a_found && a_done;
   assign bus.stall_a    = a_found && !a_done;
   assign bus.fwd_a_data = (a_found && a_done) ? a_data : '0;
   assign bus.fwd_b_hit  = b_found && b_done;
   assign bus.stall_b    = b_found && !b_done;
   assign bus.fwd_b_data = (b_found && b_done) ? b_data : '0;

endmodule

// File: tb/tb_core_wb_rob.sv
// Bench for core_wb_rob: directed scenarios plus randomized traffic checked
// against a queue-based in-order completion model.
module tb_core_wb_rob;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int REG_AW = 5;
   localparam int DEPTH  = 4;
   localparam int TAG_W  = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   core_wb_rob_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) bus ();

   core_wb_rob #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit                wb;
      logic [REG_AW-1:0] regd;
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] data;
      bit                done;
      int                tag;
   } ent_t;

   ent_t mq[$];
   int   next_tag = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   function automatic bit m_ready();
      return (mq.size() < DEPTH) && !bus.ex_halt;
   endfunction

   function automatic bit m_retire();
      return !bus.ex_halt && (mq.size() > 0) && mq[0].done;
   endfunction

   // Returns {hit, stall, data} for the youngest register producer.
   function automatic logic [DATA_W+1:0] m_fwd(input logic [REG_AW-1:0] a);
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].wb && mq[i].regd == a) begin
            if (mq[i].done) return {1'b1, 1'b0, mq[i].data};
            return {1'b0, 1'b1, {DATA_W{1'b0}}};
         end
      end
      return '0;
   endfunction

   task automatic model_step();
      bit   ret, iss, found;
      ent_t e;
      if (bus.ex_flush) begin
         mq.delete();
         next_tag = 0;
         return;
      end
      ret = m_retire();
      iss = bus.id_valid && m_ready();
      if (bus.cpl_valid) begin
         found = 1'b0;
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].tag == int'(bus.cpl_tag) && !mq[i].done) begin
               e = mq[i]; e.done = 1'b1; e.data = bus.cpl_data; mq[i] = e;
               found = 1'b1;
            end
         end
         n_cmp++;
         if (!found) begin
            n_err++;
            $display("FAIL cpl_legal: completion to tag %0d which is not pending", bus.cpl_tag);
         end
      end
      if (ret) void'(mq.pop_front());
      if (iss) begin
         e.wb   = bus.id_wb;
         e.regd = bus.id_regd;
         e.pc   = bus.id_pc;
         e.data = bus.id_done ? bus.id_data : '0;
         e.done = bus.id_done;
         e.tag  = next_tag;
         next_tag = (next_tag + 1) % DEPTH;
         mq.push_back(e);
      end
   endtask

   task automatic tick();
      if (rst) model_step();
      else begin mq.delete(); next_tag = 0; end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      bus.ex_halt = 1'b0; bus.ex_flush = 1'b0;
      bus.id_valid = 1'b0; bus.id_wb = 1'b0; bus.id_regd = '0; bus.id_pc = '0;
      bus.id_done = 1'b0; bus.id_data = '0;
      bus.cpl_valid = 1'b0; bus.cpl_tag = '0; bus.cpl_data = '0;
      bus.rd_a_addr = '0; bus.rd_b_addr = '0;
   endtask

   task automatic drive_issue(input bit w, input int rd, input logic [ADDR_W-1:0] pc,
                              input bit dn, input logic [DATA_W-1:0] d);
      bus.id_valid = 1'b1; bus.id_wb = w; bus.id_regd = REG_AW'(rd);
      bus.id_pc = pc; bus.id_done = dn; bus.id_data = d;
   endtask

   task automatic drive_cpl(input int t, input logic [DATA_W-1:0] d);
      bus.cpl_valid = 1'b1; bus.cpl_tag = TAG_W'(t); bus.cpl_data = d;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0; mq.delete(); next_tag = 0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b1; #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0; mq.delete(); next_tag = 0;
      #3;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc, bus.id_tag} !== '0) begin
         n_err++;
         $display("FAIL reset_out: got %h want 0", {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc, bus.id_tag});
      end
      n_cmp++;
      if ({bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data, bus.fwd_b_hit, bus.stall_b, bus.fwd_b_data} !== '0) begin
         n_err++; $display("FAIL reset_fwd: forward/stall outputs not zero");
      end
      n_cmp++;
      if (bus.id_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.id_ready); end
      bus.ex_halt = 1'b1; #1;
      n_cmp++;
      if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL reset_halt_ready: got %b want 0", bus.id_ready); end
      bus.ex_halt = 1'b0;
      @(posedge clk); #1; rst = 1'b1; #1;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         if (k < 3) drive_issue(1'b1, k + 1, ADDR_W'(32'h100 + 4 * k), 1'b1, DATA_W'(32'h11 * (k + 1)));
         else idle();
         #1;
         if (k == 0) begin
            n_cmp++;
            if ({bus.id_ready, bus.id_tag, bus.wb} !== {1'b1, 2'd0, 1'b0}) begin
               n_err++; $display("FAIL b2b_first: got %b want 1000", {bus.id_ready, bus.id_tag, bus.wb});
            end
         end else begin
            n_cmp++;
            if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc} !==
                {1'b1, REG_AW'(k), DATA_W'(32'h11 * k), ADDR_W'(32'h100 + 4 * (k - 1))}) begin
               n_err++;
               $display("FAIL b2b_wb%0d: got %h want %h", k, {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc},
                        {1'b1, REG_AW'(k), DATA_W'(32'h11 * k), ADDR_W'(32'h100 + 4 * (k - 1))});
            end
         end
         tick();
      end
      #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc} !== '0) begin
         n_err++; $display("FAIL b2b_empty: got %h want 0", {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc});
      end
   endtask

   task automatic test_late_result();
      do_reset();
      drive_issue(1'b1, 4, 32'h200, 1'b0, '0); #1;
      n_cmp++;
      if (bus.id_tag !== 2'd0) begin n_err++; $display("FAIL late_tag0: got %0d want 0", bus.id_tag); end
      tick();
      drive_issue(1'b1, 5, 32'h204, 1'b1, 32'h55); #1;
      n_cmp++;
      if ({bus.id_tag, bus.wb} !== {2'd1, 1'b0}) begin
         n_err++; $display("FAIL late_tag1: got %b want 010", {bus.id_tag, bus.wb});
      end
      tick();
      idle();
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++;
         if ({bus.wb, bus.ex_pc} !== {1'b0, 32'h200}) begin
            n_err++; $display("FAIL late_wait%0d: got %h want %h", k, {bus.wb, bus.ex_pc}, {1'b0, 32'h200});
         end
         tick();
      end
      drive_cpl(0, 32'hDEAD); #1;
      n_cmp++;
      if (bus.wb !== 1'b0) begin n_err++; $display("FAIL late_nobypass: got %b want 0", bus.wb); end
      tick();
      idle(); #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc} !== {1'b1, 5'd4, 32'hDEAD, 32'h200}) begin
         n_err++; $display("FAIL late_wb_ld: got %h", {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc});
      end
      tick(); #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc} !== {1'b1, 5'd5, 32'h55, 32'h204}) begin
         n_err++; $display("FAIL late_wb_add: got %h", {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc});
      end
      tick(); #1;
      n_cmp++;
      if (bus.wb !== 1'b0) begin n_err++; $display("FAIL late_after: got %b want 0", bus.wb); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive_issue(1'b1, 7 + k, ADDR_W'(32'h300 + 4 * k), 1'b0, '0); #1;
         n_cmp++;
         if ({bus.id_ready, bus.id_tag} !== {1'b1, TAG_W'(k)}) begin
            n_err++; $display("FAIL full_fill%0d: got %b", k, {bus.id_ready, bus.id_tag});
         end
         tick();
      end
      drive_issue(1'b1, 20, 32'h400, 1'b1, 32'h77); #1;
      n_cmp++;
      if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.id_ready); end
      tick();
      idle(); drive_cpl(0, 32'hA0); #1;
      n_cmp++;
      if (bus.id_ready !== 1'b0) begin n_err++; $display("FAIL full_cpl_ready: got %b want 0", bus.id_ready); end
      tick();
      idle(); #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.id_ready} !== {1'b1, 5'd7, 32'hA0, 1'b0}) begin
         n_err++; $display("FAIL full_pop: got %h", {bus.wb, bus.wb_addr, bus.wb_data, bus.id_ready});
      end
      tick(); #1;
      n_cmp++;
      if ({bus.id_ready, bus.id_tag} !== {1'b1, 2'd0}) begin
         n_err++; $display("FAIL full_wrap: got %b want 100", {bus.id_ready, bus.id_tag});
      end
      drive_issue(1'b1, 21, 32'h404, 1'b1, 32'h21);
      tick();
      idle(); bus.rd_a_addr = 5'd20; bus.rd_b_addr = 5'd21; #1;
      n_cmp++;
      if ({bus.ex_pc, bus.fwd_a_hit, bus.stall_a, bus.fwd_b_hit, bus.fwd_b_data} !==
          {32'h304, 1'b0, 1'b0, 1'b1, 32'h21}) begin
         n_err++; $display("FAIL full_after: got %h", {bus.ex_pc, bus.fwd_a_hit, bus.stall_a, bus.fwd_b_hit, bus.fwd_b_data});
      end
   endtask

   task automatic test_forward();
      do_reset();
      drive_issue(1'b1, 9, 32'h500, 1'b0, '0); tick();
      drive_issue(1'b1, 6, 32'h504, 1'b1, 32'h1); tick();
      idle(); bus.rd_a_addr = 5'd6; #1;
      n_cmp++;
      if ({bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data} !== {1'b1, 1'b0, 32'h1}) begin
         n_err++; $display("FAIL fwd_old: got %h", {bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data});
      end
      drive_issue(1'b1, 6, 32'h508, 1'b0, '0); tick();
      idle(); bus.rd_a_addr = 5'd6; bus.rd_b_addr = 5'd9; #1;
      n_cmp++;
      if ({bus.fwd_a_hit, bus.stall_a, bus.fwd_b_hit, bus.stall_b} !== 4'b0101) begin
         n_err++; $display("FAIL fwd_stall: got %b want 0101", {bus.fwd_a_hit, bus.stall_a, bus.fwd_b_hit, bus.stall_b});
      end
      bus.rd_b_addr = 5'd3; drive_cpl(2, 32'h2); #1;
      n_cmp++;
      if ({bus.stall_a, bus.fwd_b_hit, bus.stall_b, bus.fwd_b_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL fwd_nomatch: got %h", {bus.stall_a, bus.fwd_b_hit, bus.stall_b, bus.fwd_b_data});
      end
      tick();
      idle(); bus.rd_a_addr = 5'd6; #1;
      n_cmp++;
      if ({bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data} !== {1'b1, 1'b0, 32'h2}) begin
         n_err++; $display("FAIL fwd_young: got %h want %h", {bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data}, {1'b1, 1'b0, 32'h2});
      end
   endtask

   task automatic test_halt();
      do_reset();
      drive_issue(1'b1, 11, 32'h600, 1'b0, '0); tick();
      drive_issue(1'b1, 12, 32'h604, 1'b0, '0); tick();
      drive_issue(1'b1, 13, 32'h608, 1'b1, 32'h13); tick();
      idle(); bus.ex_halt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 0) begin drive_cpl(0, 32'hB0); drive_issue(1'b1, 14, 32'h60c, 1'b1, 32'h14); end
         else begin bus.cpl_valid = 1'b0; bus.id_valid = 1'b0; end
         #1;
         n_cmp++;
         if ({bus.wb, bus.id_ready} !== 2'b00) begin
            n_err++; $display("FAIL halt_cyc%0d: got %b want 00", k, {bus.wb, bus.id_ready});
         end
         tick();
      end
      idle(); #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd11, 32'hB0}) begin
         n_err++; $display("FAIL halt_release: got %h", {bus.wb, bus.wb_addr, bus.wb_data});
      end
      tick(); drive_cpl(1, 32'hB1); #1;
      n_cmp++;
      if ({bus.wb, bus.ex_pc} !== {1'b0, 32'h604}) begin
         n_err++; $display("FAIL halt_wait: got %h", {bus.wb, bus.ex_pc});
      end
      tick(); idle(); #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data} !== {1'b1, 5'd12, 32'hB1}) begin
         n_err++; $display("FAIL halt_wb12: got %h", {bus.wb, bus.wb_addr, bus.wb_data});
      end
      tick(); #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.id_tag} !== {1'b1, 5'd13, 32'h13, 2'd3}) begin
         n_err++; $display("FAIL halt_wb13: got %h", {bus.wb, bus.wb_addr, bus.wb_data, bus.id_tag});
      end
      tick();
   endtask

   task automatic test_flush();
      do_reset();
      drive_issue(1'b1, 1, 32'h700, 1'b0, '0); tick();
      drive_issue(1'b1, 2, 32'h704, 1'b0, '0); tick();
      drive_issue(1'b1, 3, 32'h708, 1'b1, 32'h33); tick();
      drive_issue(1'b1, 4, 32'h70c, 1'b1, 32'h44); drive_cpl(0, 32'hC0); bus.ex_flush = 1'b1; #1;
      n_cmp++;
      if (bus.wb !== 1'b0) begin n_err++; $display("FAIL flush_cyc: got %b want 0", bus.wb); end
      tick();
      idle(); bus.rd_a_addr = 5'd4; bus.rd_b_addr = 5'd1; #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc, bus.id_tag, bus.id_ready} !== {71'd0, 1'b1}) begin
         n_err++; $display("FAIL flush_empty: got %h", {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc, bus.id_tag, bus.id_ready});
      end
      n_cmp++;
      if ({bus.fwd_a_hit, bus.stall_a, bus.fwd_b_hit, bus.stall_b} !== 4'b0000) begin
         n_err++; $display("FAIL flush_fwd: got %b want 0000", {bus.fwd_a_hit, bus.stall_a, bus.fwd_b_hit, bus.stall_b});
      end
      tick(); #1;
      n_cmp++;
      if (bus.wb !== 1'b0) begin n_err++; $display("FAIL flush_after: got %b want 0", bus.wb); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_issue(1'b1, 1, 32'h800, 1'b1, 32'h5); tick();
      drive_issue(1'b1, 2, 32'h804, 1'b1, 32'h6); #1;
      rst = 1'b0; mq.delete(); next_tag = 0; #1;
      n_cmp++;
      if ({bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc, bus.id_tag} !== '0) begin
         n_err++; $display("FAIL rstmid_out: got %h want 0", {bus.wb, bus.wb_addr, bus.wb_data, bus.ex_pc, bus.id_tag});
      end
      #1; rst = 1'b1; idle();
      tick(); #1;
      n_cmp++;
      if ({bus.wb, bus.ex_pc} !== '0) begin
         n_err++; $display("FAIL rstmid_after: got %h want 0", {bus.wb, bus.ex_pc});
      end
   endtask

   task automatic test_random();
      int                pend[$];
      logic [DATA_W+1:0] fa, fb;
      bit                ewb;
      logic [REG_AW-1:0] eaddr;
      logic [DATA_W-1:0] edata;
      logic [ADDR_W-1:0] epc;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         bus.ex_flush  = ($urandom_range(0, 39) == 0);
         bus.ex_halt   = ($urandom_range(0, 9) == 0);
         bus.id_valid  = ($urandom_range(0, 9) < 6);
         bus.id_wb     = ($urandom_range(0, 3) != 0);
         bus.id_regd   = REG_AW'($urandom_range(0, 7));
         bus.id_pc     = $urandom;
         bus.id_done   = ($urandom_range(0, 1) == 1);
         bus.id_data   = $urandom;
         bus.rd_a_addr = REG_AW'($urandom_range(0, 7));
         bus.rd_b_addr = REG_AW'($urandom_range(0, 7));
         pend.delete();
         foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].tag);
         bus.cpl_data  = $urandom;
         bus.cpl_valid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
         bus.cpl_tag   = (pend.size() > 0) ? TAG_W'(pend[$urandom_range(0, pend.size() - 1)]) : '0;
         #1;
         ewb   = m_retire() && mq[0].wb;
         eaddr = (mq.size() > 0) ? mq[0].regd : '0;
         edata = (mq.size() > 0) ? mq[0].data : '0;
         epc   = (mq.size() > 0) ? mq[0].pc   : '0;
         fa = m_fwd(bus.rd_a_addr);
         fb = m_fwd(bus.rd_b_addr);
         n_cmp++;
         if ({bus.id_ready, bus.id_tag, bus.wb} !== {m_ready(), TAG_W'(next_tag), ewb}) begin
            n_err++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, {bus.id_ready, bus.id_tag, bus.wb}, {m_ready(), TAG_W'(next_tag), ewb});
         end
         n_cmp++;
         if ({bus.wb_addr, bus.wb_data, bus.ex_pc} !== {eaddr, edata, epc}) begin
            n_err++; $display("FAIL rnd_head c%0d: got %h want %h", c, {bus.wb_addr, bus.wb_data, bus.ex_pc}, {eaddr, edata, epc});
         end
         n_cmp++;
         if ({bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data} !== fa) begin
            n_err++; $display("FAIL rnd_fwd_a c%0d: got %h want %h", c, {bus.fwd_a_hit, bus.stall_a, bus.fwd_a_data}, fa);
         end
         n_cmp++;
         if ({bus.fwd_b_hit, bus.stall_b, bus.fwd_b_data} !== fb) begin
            n_err++; $display("FAIL rnd_fwd_b c%0d: got %h want %h", c, {bus.fwd_b_hit, bus.stall_b, bus.fwd_b_data}, fb);
         end
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      #2;
      test_reset();
      test_back_to_back();
      test_late_result();
      test_full_wrap();
      test_forward();
      test_halt();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
